// File: rtl/axi4lite_slave_mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi4lite_mem_pkg
// Shared definitions for the AXI4-Lite scratchpad slave:
//   - AXI response codes used on BRESP/RRESP
//   - arbitration mode selector
//   - write and read engine state encodings
//   - helper returning the word-index width for a given address/data width
// ---------------------------------------------------------------------------
package axi4lite_mem_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {
      ARB_RD_PRIO = 1'b0,
      ARB_RR      = 1'b1
   } arb_mode_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_RESP = 2'd2
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_REQ  = 2'd1,
      R_DATA = 2'd2
   } r_state_e;

   // The byte-offset bits below the word boundary are dropped from the
   // address, whatever remains selects a word of the array.
   function automatic int wordIdxWidth(input int addrWidth, input int dataWidth);
      return addrWidth - $clog2(dataWidth / 8);
   endfunction

endpackage

// File: rtl/axi4lite_slave_mem_arb_if.sv
// ---------------------------------------------------------------------------
// axi4lite_slave_mem_arb_if
// AXI4-Lite bus bundle between an interconnect master and the scratchpad.
//   AW channel : AWADDR, AWVALID (m->s), AWREADY (s->m)
//   W  channel : WDATA, WSTRB, WVALID (m->s), WREADY (s->m)
//   B  channel : BRESP, BVALID (s->m), BREADY (m->s)
//   AR channel : ARADDR, ARVALID (m->s), ARREADY (s->m)
//   R  channel : RDATA, RRESP, RVALID (s->m), RREADY (m->s)
// ---------------------------------------------------------------------------
interface axi4lite_slave_mem_arb_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);

   logic [ADDR_WIDTH-1:0]   AWADDR;
   logic                    AWVALID;
   logic                    AWREADY;
   logic [DATA_WIDTH-1:0]   WDATA;
   logic [DATA_WIDTH/8-1:0] WSTRB;
   logic                    WVALID;
   logic                    WREADY;
   logic [1:0]              BRESP;
   logic                    BVALID;
   logic                    BREADY;
   logic [ADDR_WIDTH-1:0]   ARADDR;
   logic                    ARVALID;
   logic                    ARREADY;
   logic [DATA_WIDTH-1:0]   RDATA;
   logic [1:0]              RRESP;
   logic                    RVALID;
   logic                    RREADY;

   modport master (
      output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/axi4lite_slave_mem_arb_mem.sv
// ---------------------------------------------------------------------------
// mem_sp_bytewe
// Single-port word array with per-byte write enables and a registered read.
//   i_clk   : clock
//   i_en    : access enable for this cycle
//   i_we    : 1 = write (byte-masked by i_wstrb), 0 = read
//   i_idx   : word index, always < DEPTH when i_en is high
//   i_wdata : write data
//   i_wstrb : byte write enables
//   o_rdata : read data, updated only on an enabled read and held otherwise
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module mem_sp_bytewe #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 48,
   parameter int IDX_WIDTH  = 6
) (
   input  logic                    i_clk,
   input  logic                    i_en,
   input  logic                    i_we,
   input  logic [IDX_WIDTH-1:0]    i_idx,
   input  logic [DATA_WIDTH-1:0]   i_wdata,
   input  logic [DATA_WIDTH/8-1:0] i_wstrb,
   output logic [DATA_WIDTH-1:0]   o_rdata
);

   localparam int STRB_W = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   // One access per cycle: either merge the strobed bytes into the addressed
   // word, or capture the addressed word into the read register. The read
   // register holds its value between reads so the R channel can stall.
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (i_wstrb[b]) begin
                  r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
               end
            end
         end else begin
            r_rdata <= r_mem[i_idx];
         end
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/axi4lite_slave_mem_arb.sv
// ---------------------------------------------------------------------------
// axi4lite_slave_mem_arb
// AXI4-Lite scratchpad slave. Independent write and read engines share one
// single-port byte-writable array through a read-priority or round-robin
// arbiter. Accesses whose word index is >= DEPTH get SLVERR: writes are
// dropped and reads return zero.
//   CLK  : clock
//   RSTn : synchronous active-low reset
//   bus  : AXI4-Lite slave port (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axi4lite_slave_mem_arb
   import axi4lite_mem_pkg::*;
#(
   parameter int        ADDR_WIDTH = 8,
   parameter int        DATA_WIDTH = 32,
   parameter int        DEPTH      = 48,
   parameter arb_mode_e ARB_MODE   = ARB_RD_PRIO
) (
   input logic                    CLK,
   input logic                    RSTn,
   axi4lite_slave_mem_arb_if.slave bus
);

   localparam int STRB_W    = DATA_WIDTH / 8;
   localparam int BYTE_OFF  = $clog2(STRB_W);
   localparam int IDX_W     = wordIdxWidth(ADDR_WIDTH, DATA_WIDTH);
   localparam int MEM_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W:0] DEPTH_C = DEPTH[IDX_W:0];

   w_state_e r_wState, w_wStateNext;
   r_state_e r_rState, w_rStateNext;

   logic                  r_active;
   logic                  r_awFull;
   logic [IDX_W-1:0]      r_awIdx;
   logic                  r_wFull;
   logic [DATA_WIDTH-1:0] r_wData;
   logic [STRB_W-1:0]     r_wStrb;
   logic [1:0]            r_bResp;
   logic [IDX_W-1:0]      r_arIdx;
   logic [1:0]            r_rResp;
   logic                  r_rdInRange;
   logic                  r_lastWasWrite;

   logic                  w_awReady, w_wReady, w_arReady;
   logic                  w_awHs, w_wHs, w_arHs;
   logic                  w_awInRange, w_arInRange;
   logic                  w_wReq, w_rReq, w_rdWinsTie;
   logic                  w_wGrant, w_rGrant;
   logic                  w_memEn;
   logic [MEM_IDX_W-1:0]  w_memIdx;
   logic [DATA_WIDTH-1:0] w_memRdata;
   logic                  w_unusedAddrLsbs;

   // Byte-offset bits never affect which word is accessed.
   assign w_unusedAddrLsbs = ^{bus.AWADDR[BYTE_OFF-1:0], bus.ARADDR[BYTE_OFF-1:0]};

   assign w_awInRange = {1'b0, r_awIdx} < DEPTH_C;
   assign w_arInRange = {1'b0, r_arIdx} < DEPTH_C;

   assign w_awHs = bus.AWVALID & w_awReady;
   assign w_wHs  = bus.WVALID  & w_wReady;
   assign w_arHs = bus.ARVALID & w_arReady;

   // Arbiter: at most one array access per cycle. In round-robin mode a tie
   // goes to whichever engine was not granted last; read priority ignores
   // the history entirely.
   always_comb begin
      w_wReq      = (r_wState == W_REQ);
      w_rReq      = (r_rState == R_REQ);
      w_rdWinsTie = (ARB_MODE == ARB_RD_PRIO) | r_lastWasWrite;
      w_rGrant    = w_rReq & (~w_wReq | w_rdWinsTie);
      w_wGrant    = w_wReq & ~w_rGrant;
   end

   // Readies are held low until the first cycle after reset is released,
   // so this flag tracks whether the previous edge saw RSTn high.
   // The arbiter pointer starts as "write was last" so the first tie
   // goes to the read engine, and only moves when somebody is granted.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_active       <= 1'b0;
         r_lastWasWrite <= 1'b1;
      end else begin
         r_active <= 1'b1;
         if (w_rGrant) begin
            r_lastWasWrite <= 1'b0;
         end else if (w_wGrant) begin
            r_lastWasWrite <= 1'b1;
         end
      end
   end

   // Write engine state register.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_wState <= W_IDLE;
      end else begin
         r_wState <= w_wStateNext;
      end
   end

   // Write engine next state and channel handshakes. Leaving W_IDLE looks
   // at this cycle's handshakes too, so the request goes out the cycle right
   // after the second of AW/W lands, in whichever order they arrive.
   always_comb begin
      w_wStateNext = r_wState;
      w_awReady    = 1'b0;
      w_wReady     = 1'b0;
      bus.BVALID   = 1'b0;
      case (r_wState)
         W_IDLE: begin
            w_awReady = r_active & ~r_awFull;
            w_wReady  = r_active & ~r_wFull;
            if ((r_awFull | w_awHs) && (r_wFull | w_wHs)) begin
               w_wStateNext = W_REQ;
            end
         end
         W_REQ: begin
            if (w_wGrant) begin
               w_wStateNext = W_RESP;
            end
         end
         W_RESP: begin
            bus.BVALID = 1'b1;
            if (bus.BREADY) begin
               w_wStateNext = W_IDLE;
            end
         end
         default: w_wStateNext = W_IDLE;
      endcase
      bus.AWREADY = w_awReady;
      bus.WREADY  = w_wReady;
   end

   // AW and W buffers fill independently and are both released once the
   // B response has been taken. BRESP is decided at the grant edge and
   // then held through W_RESP.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_awFull <= 1'b0;
         r_awIdx  <= '0;
         r_wFull  <= 1'b0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_bResp  <= RESP_OKAY;
      end else begin
         if (w_awHs) begin
            r_awFull <= 1'b1;
            r_awIdx  <= bus.AWADDR[ADDR_WIDTH-1:BYTE_OFF];
         end
         if (w_wHs) begin
            r_wFull <= 1'b1;
            r_wData <= bus.WDATA;
            r_wStrb <= bus.WSTRB;
         end
         if (w_wGrant) begin
            r_bResp <= w_awInRange ? RESP_OKAY : RESP_SLVERR;
         end
         if ((r_wState == W_RESP) && bus.BREADY) begin
            r_awFull <= 1'b0;
            r_wFull  <= 1'b0;
         end
      end
   end

   // Read engine state register.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_rState <= R_IDLE;
      end else begin
         r_rState <= w_rStateNext;
      end
   end

   // Read engine next state and handshakes: accept an address only when
   // idle, wait for the grant, then present data until RREADY.
   always_comb begin
      w_rStateNext = r_rState;
      w_arReady    = 1'b0;
      bus.RVALID   = 1'b0;
      case (r_rState)
         R_IDLE: begin
            w_arReady = r_active;
            if (w_arHs) begin
               w_rStateNext = R_REQ;
            end
         end
         R_REQ: begin
            if (w_rGrant) begin
               w_rStateNext = R_DATA;
            end
         end
         R_DATA: begin
            bus.RVALID = 1'b1;
            if (bus.RREADY) begin
               w_rStateNext = R_IDLE;
            end
         end
         default: w_rStateNext = R_IDLE;
      endcase
      bus.ARREADY = w_arReady;
   end

   // Read address capture plus the response and range flag decided at the
   // grant edge. The range flag doubles as the RDATA zeroing control, which
   // also gives RDATA=0 out of reset without touching the array.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         r_arIdx     <= '0;
         r_rResp     <= RESP_OKAY;
         r_rdInRange <= 1'b0;
      end else begin
         if (w_arHs) begin
            r_arIdx <= bus.ARADDR[ADDR_WIDTH-1:BYTE_OFF];
         end
         if (w_rGrant) begin
            r_rResp     <= w_arInRange ? RESP_OKAY : RESP_SLVERR;
            r_rdInRange <= w_arInRange;
         end
      end
   end

   // Out-of-range grants never touch the array, and nothing is written or
   // read at an edge where reset is asserted.
   assign w_memEn  = RSTn & ((w_wGrant & w_awInRange) | (w_rGrant & w_arInRange));
   assign w_memIdx = w_wGrant ? r_awIdx[MEM_IDX_W-1:0] : r_arIdx[MEM_IDX_W-1:0];

   mem_sp_bytewe #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .IDX_WIDTH  (MEM_IDX_W)
   ) u_mem (
      .i_clk   (CLK),
      .i_en    (w_memEn),
      .i_we    (w_wGrant),
      .i_idx   (w_memIdx),
      .i_wdata (r_wData),
      .i_wstrb (r_wStrb),
      .o_rdata (w_memRdata)
   );

   assign bus.BRESP = r_bResp;
   assign bus.RRESP = r_rResp;
   assign bus.RDATA = r_rdInRange ? w_memRdata : '0;

endmodule
